// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

  localparam int INSN_W = 16;
  localparam logic [INSN_W-1:0] BUBBLE_DEF    = 16'hF800;
  localparam logic [INSN_W-1:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/ifetch_unit_prog_mem.sv
// Program store: single synchronous write port, asynchronous read, no reset on storage.
module prog_mem
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INSN_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INSN_W-1:0] rdata
);

  logic [INSN_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction supply stage: loadable program store, run/halt gating and bubble insertion.
// Optional macro FETCH_CNT_EN adds the fetch_cnt output counting new-PC fetches.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int              DEPTH     = 256,
  parameter int              AW        = 8,
  parameter logic [15:0]     BUBBLE    = BUBBLE_DEF,
  parameter logic [15:0]     HALT_WORD = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_clr,
  input  logic        prog_we,
  input  logic [15:0] prog_data,
  input  logic        start,
  input  logic [15:0] addr,
  output logic [15:0] ins,
  output logic        running,
  output logic        halted,
`ifdef FETCH_CNT_EN
  output logic [15:0] fetch_cnt,
`endif
  output logic [AW:0] prog_len
);

  localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);

  state_e      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic        running_q, running_d;
  logic        halted_q, halted_d;

  logic [15:0] mem_word;
  logic        in_range;
  logic        is_halt_word;
  logic        word_ok;
  logic        fetch_en;
  logic        wr_en;

  // Load pointer and length always advance together, so len_q doubles as the pointer.
  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (len_q[AW-1:0]),
    .wdata (prog_data),
    .raddr (addr[AW-1:0]),
    .rdata (mem_word)
  );

  // Widened compare so any set address bit above AW lands out of range.
  assign in_range     = {1'b0, addr} < 17'(len_q);
  assign is_halt_word = (mem_word == HALT_WORD);
  assign word_ok      = in_range && !is_halt_word;
  assign fetch_en     = (state_q == RUN) && word_ok;

  assign wr_en = reset && (state_q != RUN) && !prog_clr && prog_we && (len_q != FULL_LEN);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      RUN: begin
        if (!word_ok) begin
          state_d = HALT;
        end
      end
      IDLE, HALT: begin
        if (prog_clr) begin
          len_d   = '0;
          state_d = IDLE;
        end else begin
          if (wr_en) begin
            len_d = len_q + 1'b1;
          end
          if (start && (len_q != '0)) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    halted_d  = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  assign ins      = (reset && fetch_en) ? mem_word : BUBBLE;
  assign running  = running_q;
  assign halted   = halted_q;
  assign prog_len = len_q;

`ifdef FETCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] prev_addr_q;
  logic        prev_vld_q, prev_vld_d;

  // The first RUN cycle has no previous PC, so its fetch always counts as new.
  always_comb begin
    cnt_d      = cnt_q;
    prev_vld_d = (state_q == RUN);
    if ((state_q != RUN) && (state_d == RUN)) begin
      cnt_d = '0;
    end else if (fetch_en && (!prev_vld_q || (addr != prev_addr_q)) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      prev_addr_q <= '0;
      prev_vld_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prev_addr_q <= addr;
      prev_vld_q  <= prev_vld_d;
    end
  end

  assign fetch_cnt = cnt_q;
`endif

endmodule
